register_file: RTL and testbench

//  Architectural integer register file for the single-cycle datapath.
//  - Sits directly upstream of the ALU: drives the ALU operand buses BusA and BusB.
//  - Accepts the writeback value (ALU result or memory load) on BusW.
//  - Two combinational read ports, one clocked write port.
//  - Register ZERO_REG is hardwired to zero (XZR).
//  - Optional write-to-read bypass, so the value being written this cycle is

---
 rtl/register_file.sv | 70 +++++++
 tb/tb_register_file.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural integer register file: two combinational read ports, one clocked
// write port, a hardwired zero register and optional same-cycle write bypass.
module register_file #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [AW-1:0]    RA,
    input  logic [AW-1:0]    RB,
    input  logic [AW-1:0]    RW,
    input  logic             RegWr,
    input  logic [WIDTH-1:0] BusW,
    output logic [WIDTH-1:0] BusA,
    output logic [WIDTH-1:0] BusB
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [WIDTH-1:0] regs_r [NREGS];
    logic             wr_en_s;

    // Addresses past the end of a non-power-of-two array behave like the zero register.
    function automatic logic addr_valid(input logic [AW-1:0] addr);
        return (int'({1'b0, addr}) < NREGS) && (addr != ZERO_ADDR);
    endfunction

    // Read mux shared by both ports; reset forces zero and suppresses bypass.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] data;
        if (!Rst_n) begin
            data = '0;
        end else if (!addr_valid(addr)) begin
            data = '0;
        end else if ((BYPASS != 0) && RegWr && (RW == addr)) begin
            data = BusW;
        end else begin
            data = regs_r[addr];
        end
        return data;
    endfunction

    // Write qualifier: discards writes to the zero register and out-of-range entries.
    always_comb begin
        wr_en_s = RegWr && addr_valid(RW);
    end

    // Register array state with asynchronous clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_r[RW] <= BusW;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Combinational read ports.
    always_comb begin
        BusA = read_port(RA);
        BusB = read_port(RB);
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: one instance with bypass, one without,
// driven from the same stimulus.
module tb_register_file;

    localparam int W = 64;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ra, rb, rw;
    logic          regwr;
    logic [W-1:0]  busw;
    logic [W-1:0]  busa1, busb1, busa0, busb0;

    int n_checks = 0;
    int n_fail   = 0;

    register_file #(.WIDTH(W), .NREGS(32), .ZERO_REG(31), .BYPASS(1)) u_byp (
        .Clk(clk), .Rst_n(rst_n), .RA(ra), .RB(rb), .RW(rw),
        .RegWr(regwr), .BusW(busw), .BusA(busa1), .BusB(busb1)
    );

    register_file #(.WIDTH(W), .NREGS(32), .ZERO_REG(31), .BYPASS(0)) u_nobyp (
        .Clk(clk), .Rst_n(rst_n), .RA(ra), .RB(rb), .RW(rw),
        .RegWr(regwr), .BusW(busw), .BusA(busa0), .BusB(busb0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] rw;
        logic          wr;
        logic [W-1:0]  busw;
        logic [W-1:0]  a1;
        logic [W-1:0]  b1;
        logic [W-1:0]  a0;
        logic [W-1:0]  b0;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [W-1:0] a1, input logic [W-1:0] b1,
                             input logic [W-1:0] a0, input logic [W-1:0] b0);
        check({name, "_a_byp"}, busa1, a1);
        check({name, "_b_byp"}, busb1, b1);
        check({name, "_a_nobyp"}, busa0, a0);
        check({name, "_b_nobyp"}, busb0, b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_a, exp_b;

        vecs[0]  = '{5'd3,  5'd3,  5'd3,  1'b1, 64'h0123_4567_89AB_CDEF,
                     64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0};
        vecs[1]  = '{5'd3,  5'd3,  5'd0,  1'b0, 64'h0,
                     64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                     64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vecs[2]  = '{5'd31, 5'd3,  5'd31, 1'b1, {64{1'b1}},
                     64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF};
        vecs[3]  = '{5'd31, 5'd3,  5'd31, 1'b0, {64{1'b1}},
                     64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF};
        vecs[4]  = '{5'd7,  5'd31, 5'd7,  1'b1, 64'h10, 64'h10, 64'h0, 64'h0, 64'h0};
        vecs[5]  = '{5'd7,  5'd7,  5'd7,  1'b1, 64'h20, 64'h20, 64'h20, 64'h10, 64'h10};
        vecs[6]  = '{5'd7,  5'd3,  5'd0,  1'b0, 64'h0,
                     64'h20, 64'h0123_4567_89AB_CDEF, 64'h20, 64'h0123_4567_89AB_CDEF};
        vecs[7]  = '{5'd9,  5'd9,  5'd9,  1'b1, 64'h99, 64'h99, 64'h99, 64'h0, 64'h0};
        vecs[8]  = '{5'd9,  5'd7,  5'd9,  1'b0, 64'hFF, 64'h99, 64'h20, 64'h99, 64'h20};
        vecs[9]  = '{5'd9,  5'd0,  5'd9,  1'b0, 64'hFF, 64'h99, 64'h0, 64'h99, 64'h0};
        vecs[10] = '{5'd0,  5'd1,  5'd0,  1'b1, 64'hA5, 64'hA5, 64'h0, 64'h0, 64'h0};
        vecs[11] = '{5'd0,  5'd31, 5'd0,  1'b0, 64'h0, 64'hA5, 64'h0, 64'hA5, 64'h0};
        vecs[12] = '{5'd7,  5'd9,  5'd3,  1'b1, 64'h55, 64'h20, 64'h99, 64'h20, 64'h99};
        vecs[13] = '{5'd3,  5'd3,  5'd0,  1'b0, 64'h0, 64'h55, 64'h55, 64'h55, 64'h55};

        // Reset: outputs zero and an edge under reset writes nothing.
        rst_n = 1'b0;
        ra = 5'd4; rb = 5'd5; rw = 5'd4; regwr = 1'b1; busw = 64'h44;
        #2;
        check_all("reset_out", 64'h0, 64'h0, 64'h0, 64'h0);
        tick();
        rst_n = 1'b1; regwr = 1'b0;
        #1;
        check_all("no_write_in_reset", 64'h0, 64'h0, 64'h0, 64'h0);

        rw = 5'd5; busw = 64'hDEAD; regwr = 1'b1;
        tick();
        regwr = 1'b0; ra = 5'd5; rb = 5'd5;
        #1;
        check_all("load_dead", 64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD);
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 64'h0, 64'h0, 64'h0, 64'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check_all("after_release", 64'h0, 64'h0, 64'h0, 64'h0);
        tick();
        check_all("after_release_edge", 64'h0, 64'h0, 64'h0, 64'h0);

        // Directed vectors: pre-edge reads, then the edge commits any write.
        for (int i = 0; i < 14; i++) begin
            ra = vecs[i].ra; rb = vecs[i].rb; rw = vecs[i].rw;
            regwr = vecs[i].wr; busw = vecs[i].busw;
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].a1, vecs[i].b1, vecs[i].a0, vecs[i].b0);
            tick();
        end
        regwr = 1'b0;

        // Sweep: fill every writable register, then read mirrored pairs.
        for (int i = 0; i < 31; i++) begin
            rw = AW'(i); busw = 64'(i) * 64'h0101; regwr = 1'b1;
            tick();
        end
        regwr = 1'b0;
        for (int i = 0; i < 31; i++) begin
            ra = AW'(i); rb = AW'(30 - i);
            #1;
            exp_a = 64'(i) * 64'h0101;
            exp_b = 64'(30 - i) * 64'h0101;
            check_all($sformatf("sweep%0d", i), exp_a, exp_b, exp_a, exp_b);
        end
        ra = 5'd31; rb = 5'd31;
        #1;
        check_all("sweep_zero", 64'h0, 64'h0, 64'h0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
